dt_sti_loader: RTL and testbench

- Front-end stage of the distance-transform datapath.
- Reads the packed 128x128 binary image from the stimulus ROM. The image is 1024 words of 16 bits, 1 bit per pixel.
- Expands it into the 8-bit-per-pixel result RAM (16384 bytes), writing foreground/background values so the forward pass starts from an initialised RAM.
- Runs on a start/busy/done handshake; the DT pass FSM starts it and waits for it.

---
 rtl/dt_pkg.sv | 28 ++
 rtl/dt_sti_loader_if.sv | 28 ++
 rtl/dt_sti_loader.sv | 145 ++++++++++++++
 tb/tb_dt_sti_loader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// Shared definitions for the distance-transform datapath: image geometry,
// memory address widths and the loader/pass state encoding.
package dt_pkg;

   localparam int IMG_W     = 128;
   localparam int IMG_H     = 128;
   localparam int STI_WORDS = 1024;
   localparam int STI_AW    = 10;
   localparam int RES_AW    = 14;
   localparam int PIX_W     = 8;

   localparam logic [RES_AW-1:0] LAST_PIX  = RES_AW'(IMG_W*IMG_H - 1);
   localparam logic [STI_AW-1:0] LAST_WORD = STI_AW'(STI_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // True when a result-RAM pixel address lies on the outer image frame.
   function automatic logic on_border(input logic [RES_AW-1:0] a);
      return (a[13:7] == 7'd0) || (a[13:7] == 7'(IMG_H - 1)) ||
             (a[6:0]  == 7'd0) || (a[6:0]  == 7'(IMG_W - 1));
   endfunction

endpackage

// File: rtl/dt_sti_loader_if.sv
// Handshake plus stimulus-ROM and result-RAM buses of the STI loader.
// master = the loader, slave = the controlling FSM and the memories.
interface dt_sti_loader_if
   import dt_pkg::*;
();

   logic              start;
   logic              busy;
   logic              done;
   logic              sti_rd;
   logic [STI_AW-1:0] sti_addr;
   logic [15:0]       sti_di;
   logic              res_wr;
   logic              res_rd;
   logic [RES_AW-1:0] res_addr;
   logic [PIX_W-1:0]  res_do;

   modport master (
      input  start, sti_di,
      output busy, done, sti_rd, sti_addr, res_wr, res_rd, res_addr, res_do
   );

   modport slave (
      output start, sti_di,
      input  busy, done, sti_rd, sti_addr, res_wr, res_rd, res_addr, res_do
   );

endinterface

// File: rtl/dt_sti_loader.sv
// Expands the packed 1-bit-per-pixel stimulus ROM into the byte-per-pixel
// result RAM, one pixel per cycle, prefetching the next ROM word during the
// last pixel of the current one so the write stream has no gaps.
module dt_sti_loader
   import dt_pkg::*;
#(
   parameter logic [PIX_W-1:0] FG_VAL      = 8'd1,
   parameter logic [PIX_W-1:0] BG_VAL      = 8'd0,
   parameter bit               WRITE_BG    = 1'b1,
   parameter bit               BORDER_ZERO = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   dt_sti_loader_if.master bus
);

   state_t            state, state_nx;
   logic              busy_r, busy_nx;
   logic              done_r, done_nx;
   logic              sti_rd_r, sti_rd_nx;
   logic [STI_AW-1:0] sti_addr_r, sti_addr_nx;
   logic              res_wr_r, res_wr_nx;
   logic [RES_AW-1:0] res_addr_r, res_addr_nx;
   logic [PIX_W-1:0]  res_do_r, res_do_nx;
   logic [15:0]       sh_r, sh_nx;

   logic              drive;
   logic              pix_bit;
   logic              pix_fg;
   logic [RES_AW-1:0] pix_addr;

   // A pixel is foreground only if its ROM bit is set and the frame is not forced.
   function automatic logic is_fg(input logic b, input logic [RES_AW-1:0] a);
      return b && !(BORDER_ZERO && on_border(a));
   endfunction

   function automatic logic [PIX_W-1:0] pix_byte(input logic fg);
      return fg ? FG_VAL : BG_VAL;
   endfunction

   // res_addr doubles as the pixel counter; the ROM word is its upper bits.
   // Next-state and next-output logic; every register holds by default.
   always_comb begin
      state_nx    = state;
      busy_nx     = busy_r;
      done_nx     = done_r;
      sti_rd_nx   = 1'b0;
      sti_addr_nx = sti_addr_r;
      res_wr_nx   = 1'b0;
      res_addr_nx = res_addr_r;
      res_do_nx   = res_do_r;
      sh_nx       = sh_r;
      drive       = 1'b0;
      pix_bit     = 1'b0;
      pix_fg      = 1'b0;
      pix_addr    = res_addr_r + 1'b1;

      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               state_nx    = FETCH;
               sti_rd_nx   = 1'b1;
               sti_addr_nx = '0;
               busy_nx     = 1'b1;
               done_nx     = 1'b0;
            end
         end
         FETCH: begin
            state_nx = WRITE;
            pix_addr = '0;
            pix_bit  = bus.sti_di[15];
            sh_nx    = {bus.sti_di[14:0], 1'b0};
            drive    = 1'b1;
         end
         WRITE: begin
            if (res_addr_r == LAST_PIX) begin
               state_nx = DONE;
               busy_nx  = 1'b0;
               done_nx  = 1'b1;
            end else begin
               if (pix_addr[3:0] == 4'd0) begin
                  pix_bit = bus.sti_di[15];
                  sh_nx   = {bus.sti_di[14:0], 1'b0};
               end else begin
                  pix_bit = sh_r[15];
                  sh_nx   = {sh_r[14:0], 1'b0};
               end
               drive = 1'b1;
               if ((pix_addr[3:0] == 4'hF) && (pix_addr[RES_AW-1:4] != LAST_WORD)) begin
                  sti_rd_nx   = 1'b1;
                  sti_addr_nx = pix_addr[RES_AW-1:4] + 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase

      if (drive) begin
         pix_fg      = is_fg(pix_bit, pix_addr);
         res_addr_nx = pix_addr;
         res_wr_nx   = pix_fg || WRITE_BG;
         if (res_wr_nx) begin
            res_do_nx = pix_byte(pix_fg);
         end
      end
   end

   // Control and output registers; reset aborts a run at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         sti_rd_r   <= 1'b0;
         sti_addr_r <= '0;
         res_wr_r   <= 1'b0;
         res_addr_r <= '0;
         res_do_r   <= '0;
      end else begin
         state      <= state_nx;
         busy_r     <= busy_nx;
         done_r     <= done_nx;
         sti_rd_r   <= sti_rd_nx;
         sti_addr_r <= sti_addr_nx;
         res_wr_r   <= res_wr_nx;
         res_addr_r <= res_addr_nx;
         res_do_r   <= res_do_nx;
      end
   end

   // Pixel shift register; always loaded from the ROM before it is read.
   always_ff @(posedge clk) begin
      sh_r <= sh_nx;
   end

   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.sti_rd   = sti_rd_r;
   assign bus.sti_addr = sti_addr_r;
   assign bus.res_wr   = res_wr_r;
   assign bus.res_rd   = 1'b0;
   assign bus.res_addr = res_addr_r;
   assign bus.res_do   = res_do_r;

endmodule

// File: tb/tb_dt_sti_loader.sv
// Bench for dt_sti_loader: three instances (defaults, forced border zero,
// background writes suppressed) with ROM/RAM models and a write scoreboard.
module tb_dt_sti_loader;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   dt_sti_loader_if b0();
   dt_sti_loader_if b1();
   dt_sti_loader_if b2();

   dt_sti_loader u0 (.clk(clk), .reset(reset), .bus(b0));
   dt_sti_loader #(.BORDER_ZERO(1'b1)) u1 (.clk(clk), .reset(reset), .bus(b1));
   dt_sti_loader #(.WRITE_BG(1'b0))    u2 (.clk(clk), .reset(reset), .bus(b2));

   logic [15:0] rom0 [1024];
   logic [15:0] rom1 [1024];
   logic [15:0] rom2 [1024];
   logic [7:0]  ram0 [16384];
   logic [7:0]  ram1 [16384];
   logic [7:0]  ram2 [16384];

   logic [21:0] q0 [$];
   logic [21:0] q1 [$];
   logic [21:0] q2 [$];

   int n_cmp = 0;
   int n_err = 0;
   int cycle = 0;
   int wc0 = 0, wc1 = 0, wc2 = 0;
   int t0 [3];
   bit rd_hi = 1'b0;
   bit busy_done = 1'b0;
   bit done_seen0 = 1'b0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   always @(posedge clk) cycle <= cycle + 1;

   // ROM models: capture on negedge while sti_rd is high.
   initial forever begin
      @(negedge clk);
      if (b0.sti_rd) b0.sti_di = rom0[b0.sti_addr];
      if (b1.sti_rd) b1.sti_di = rom1[b1.sti_addr];
      if (b2.sti_rd) b2.sti_di = rom2[b2.sti_addr];
   end

   // RAM models: write on posedge.
   initial forever begin
      @(posedge clk);
      if (b0.res_wr) ram0[b0.res_addr] = b0.res_do;
      if (b1.res_wr) ram1[b1.res_addr] = b1.res_do;
      if (b2.res_wr) ram2[b2.res_addr] = b2.res_do;
   end

   // Write monitors: pop the scoreboard on every observed write.
   initial forever begin
      @(negedge clk);
      if (b0.res_rd || b1.res_rd || b2.res_rd) rd_hi = 1'b1;
      if ((b0.busy && b0.done) || (b1.busy && b1.done) || (b2.busy && b2.done)) busy_done = 1'b1;
      if (b0.done) done_seen0 = 1'b1;
      if (b0.res_wr) begin
         wc0++;
         if (q0.size() == 0) chk("wr0_extra", 1, 0);
         else chk("wr0", {b0.res_addr, b0.res_do}, q0.pop_front());
      end
      if (b1.res_wr) begin
         wc1++;
         if (q1.size() == 0) chk("wr1_extra", 1, 0);
         else chk("wr1", {b1.res_addr, b1.res_do}, q1.pop_front());
      end
      if (b2.res_wr) begin
         wc2++;
         if (q2.size() == 0) chk("wr2_extra", 1, 0);
         else chk("wr2", {b2.res_addr, b2.res_do}, q2.pop_front());
      end
   end

   function automatic logic [15:0] rom_word(input int inst, input int w);
      case (inst)
         0:       return rom0[w];
         1:       return rom1[w];
         default: return rom2[w];
      endcase
   endfunction

   function automatic logic [7:0] ram_byte(input int inst, input int a);
      case (inst)
         0:       return ram0[a];
         1:       return ram1[a];
         default: return ram2[a];
      endcase
   endfunction

   function automatic int count_val(input int inst, input logic [7:0] v,
                                    input int lo, input int hi, input int step);
      int n = 0;
      for (int a = lo; a <= hi; a += step)
         if (ram_byte(inst, a) == v) n++;
      return n;
   endfunction

   function automatic logic get_done(input int inst);
      case (inst)
         0:       return b0.done;
         1:       return b1.done;
         default: return b2.done;
      endcase
   endfunction

   function automatic logic [63:0] outs(input int inst);
      case (inst)
         0: return {27'd0, b0.busy, b0.done, b0.sti_rd, b0.sti_addr, b0.res_wr, b0.res_rd, b0.res_addr, b0.res_do};
         1: return {27'd0, b1.busy, b1.done, b1.sti_rd, b1.sti_addr, b1.res_wr, b1.res_rd, b1.res_addr, b1.res_do};
         default: return {27'd0, b2.busy, b2.done, b2.sti_rd, b2.sti_addr, b2.res_wr, b2.res_rd, b2.res_addr, b2.res_do};
      endcase
   endfunction

   task automatic set_start(input int inst, input logic v);
      case (inst)
         0:       b0.start = v;
         1:       b1.start = v;
         default: b2.start = v;
      endcase
   endtask

   // Expected write stream from the ROM image, row/col derived from the address.
   task automatic build_exp(input int inst);
      bit bz  = (inst == 1);
      bit wbg = (inst != 2);
      for (int a = 0; a < 16384; a++) begin
         int row = a / 128;
         int col = a % 128;
         logic [15:0] w = rom_word(inst, a / 16);
         logic b = w[15 - (a % 16)];
         bit border = bz && (row == 0 || row == 127 || col == 0 || col == 127);
         bit fg = b && !border;
         logic [13:0] a14 = 14'(a);
         if (fg || wbg) begin
            case (inst)
               0:       q0.push_back({a14, fg ? 8'h01 : 8'h00});
               1:       q1.push_back({a14, fg ? 8'h01 : 8'h00});
               default: q2.push_back({a14, fg ? 8'h01 : 8'h00});
            endcase
         end
      end
   endtask

   // Leaves the caller #1 after the accept edge (edge 0).
   task automatic start_run(input int inst);
      @(negedge clk);
      set_start(inst, 1'b1);
      @(posedge clk);
      #1;
      set_start(inst, 1'b0);
      t0[inst] = cycle;
   endtask

   task automatic wait_done(input int inst);
      bit found = 1'b0;
      for (int i = 0; i < 20000 && !found; i++) begin
         @(posedge clk);
         #1;
         if (get_done(inst)) found = 1'b1;
      end
      if (found) chk($sformatf("latency%0d", inst), cycle - t0[inst], 16385);
      else chk($sformatf("done_timeout%0d", inst), 0, 1);
   endtask

   initial begin
      int wcs;
      bit hit;
      b0.start = 1'b0;
      b1.start = 1'b0;
      b2.start = 1'b0;
      for (int w = 0; w < 1024; w++) begin
         rom0[w] = (w == 0) ? 16'h8001 : 16'h0000;
         rom1[w] = 16'hFFFF;
         rom2[w] = 16'hAAAA;
      end
      for (int a = 0; a < 16384; a++) begin
         ram0[a] = 8'h55;
         ram1[a] = 8'h55;
         ram2[a] = 8'hAA;
      end

      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs0", outs(0), 0);
      chk("rst_outs1", outs(1), 0);
      chk("rst_outs2", outs(2), 0);
      @(negedge clk);
      reset = 1'b1;

      fork
         begin
            build_exp(0);
            start_run(0);
            chk("a_accept", {b0.sti_rd, b0.sti_addr, b0.busy, b0.done}, {1'b1, 10'd0, 1'b1, 1'b0});
            repeat (16) @(posedge clk);
            #1;
            chk("a_prefetch", {b0.sti_rd, b0.sti_addr}, {1'b1, 10'd1});
            repeat (84) @(posedge clk);
            #1;
            b0.start = 1'b1;
            @(posedge clk);
            #1;
            b0.start = 1'b0;
            chk("a_busy_after_restart", b0.busy, 1);
            wait_done(0);
            chk("a_ram0", ram0[0], 8'h01);
            chk("a_ram15", ram0[15], 8'h01);
            chk("a_ram1_14_zero", count_val(0, 8'h00, 1, 14, 1), 14);
         end
         begin
            build_exp(1);
            start_run(1);
            wait_done(1);
            chk("bz_ram0", ram1[0], 8'h00);
            chk("bz_ram127", ram1[127], 8'h00);
            chk("bz_ram128", ram1[128], 8'h00);
            chk("bz_ram16256", ram1[16256], 8'h00);
            chk("bz_ram16383", ram1[16383], 8'h00);
            chk("bz_ram129", ram1[129], 8'h01);
            chk("bz_ones", count_val(1, 8'h01, 0, 16383, 1), 15876);
            chk("bz_zeros", count_val(1, 8'h00, 0, 16383, 1), 16384 - 15876);
         end
         begin
            build_exp(2);
            start_run(2);
            wait_done(2);
            chk("nbg_even", count_val(2, 8'h01, 0, 16382, 2), 8192);
            chk("nbg_odd", count_val(2, 8'hAA, 1, 16383, 2), 8192);
            chk("nbg_pulses", wc2, 8192);
         end
      join
      chk("q0_empty_a", q0.size(), 0);
      chk("q1_empty", q1.size(), 0);
      chk("q2_empty", q2.size(), 0);

      // Second pass from DONE with an all-ones image.
      for (int w = 0; w < 1024; w++) rom0[w] = 16'hFFFF;
      for (int a = 0; a < 16384; a++) ram0[a] = 8'h55;
      wcs = wc0;
      build_exp(0);
      start_run(0);
      chk("b_done_drop", {b0.done, b0.busy}, {1'b0, 1'b1});
      wait_done(0);
      chk("b_ones", count_val(0, 8'h01, 0, 16383, 1), 16384);
      chk("b_writes", wc0 - wcs, 16384);
      chk("q0_empty_b", q0.size(), 0);

      // Abort with reset while pixel 5000 is on the bus.
      build_exp(0);
      start_run(0);
      done_seen0 = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 6000 && !hit; i++) begin
         @(posedge clk);
         #1;
         if (b0.res_wr && b0.res_addr == 14'd5000) hit = 1'b1;
      end
      chk("c_reach5000", hit, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("c_abort_outs", outs(0), 0);
      chk("c_no_done", done_seen0, 0);
      q0.delete();
      wcs = wc0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("c_no_writes", wc0 - wcs, 0);
      chk("c_idle_outs", outs(0), 0);

      // Re-run after the abort.
      for (int a = 0; a < 16384; a++) ram0[a] = 8'h55;
      build_exp(0);
      start_run(0);
      wait_done(0);
      chk("d_ones", count_val(0, 8'h01, 0, 16383, 1), 16384);
      chk("q0_empty_d", q0.size(), 0);

      chk("res_rd_low", rd_hi, 0);
      chk("busy_done_excl", busy_done, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
